simple_seq: RTL and testbench
=============================

# simple_seq

Parametrised multi-cycle phase sequencer for the SIMPLE processor family. It replaces the fixed free-running five-phase counter with a controlled sequencer that offers:
- configurable phase count;
- memory wait-state handshake with timeout;
- run, single-step and halt modes;
- instruction and cycle counters for the debug display.

It sits between the debounced `exec` button and the datapath register/RAM enables.

## Interface
Parameters:
- `NPHASE`, 5, number of phases per instruction (≥2)
- `MEM_MASK`, 5'b01001, bit i set ⇒ phase i performs a memory access needing `mem_ack`
- `MAX_WAIT`, 15, unacknowledged memory cycles tolerated before error (≥0)
- `CNT_W`, 16, width of both counters

Ports:
- `clk` in 1, single system clock; all state changes on rising edge
- `rst` in 1, synchronous, active-high reset
- `exec` in 1, one-cycle pulse from chattering remover: start / pause
- `step` in 1, 1 = single-instruction mode, 0 = continuous run; sampled at instruction boundary
- `halt_req` in 1, decoder's HLT indication, sampled in last phase
- `mem_ack` in 1, memory completion, valid only while `mem_req` high
- `phase` out NPHASE, one-hot active phase; all-zero when not executing
- `mem_req` out 1, memory access in progress
- `running` out 1, high in RUN state
- `halted` out 1, high in HALT state
- `err` out 1, high in ERR (memory timeout) state
- `inst_cnt` out CNT_W, completed instructions, wraps
- `cycle_cnt` out CNT_W, clocks spent executing, saturates at all-ones

## Operation
- States: IDLE, RUN, HALT, ERR. Phase index `idx` (0..NPHASE-1) is valid in RUN only.
- IDLE: `exec` ⇒ RUN with idx=0.
- RUN, phase i with MEM_MASK[i]=0: advance idx next cycle.
- RUN, phase i with MEM_MASK[i]=1: `mem_req`=1 while in that phase. Advance on the edge where `mem_ack`=1; otherwise hold idx.
- Wait counter:
  - Counts consecutive cycles with `mem_req`=1 and `mem_ack`=0; clears on phase advance.
  - The (MAX_WAIT+1)th such cycle ⇒ ERR.
- End of last phase (advance out of idx=NPHASE-1): `inst_cnt` += 1. Next state, by priority:
  1. `halt_req` ⇒ HALT;
  2. `step`=1 or a pause pending ⇒ IDLE;
  3. otherwise RUN, idx=0.
- Pause: `exec` seen during RUN with `step`=0 sets a pause flag, honoured at the next instruction boundary. It never aborts mid-instruction. The flag clears on entering IDLE.
- HALT and ERR exit only by `rst`. `exec` is ignored there.
- `mem_ack` outside `mem_req` is ignored. `exec` during RUN with `step`=1 is ignored.
- `cycle_cnt` increments every RUN cycle, including wait cycles, and saturates.

## Timing
- All outputs are registered or decoded from registered state only; no combinational path from an input to an output.
- Reset values:
  - state IDLE, idx 0, pause flag 0, wait counter 0;
  - `phase`=0, `mem_req`=0, `running`=0, `halted`=0, `err`=0, `inst_cnt`=0, `cycle_cnt`=0.
- Reset asserted mid-instruction returns everything to the reset values on that edge, with no completion or count.
- `exec` at edge n ⇒ `phase[0]`=1 in cycle n+1.
- Non-memory phase: exactly 1 cycle.
- Memory phase: 1+k cycles, where k = unacked cycles. Ack in the first cycle gives k=0.
- Zero-wait instruction: NPHASE cycles. Back-to-back in run mode: `phase[NPHASE-1]` is immediately followed by `phase[0]`.
- Step mode: `running` falls the cycle after the last phase. The next `exec` restarts after 1 cycle.
- Simultaneous `halt_req` and pause at a boundary: HALT wins.
- `mem_ack` on the cycle that would be the timeout cycle: ack wins, no error.

## Structure
- Shared header `simple_pkg.vh`: state encodings (IDLE=2'd0, RUN=2'd1, HALT=2'd2, ERR=2'd3) and default MEM_MASK.
- One sub-module `simple_seq_wait`: wait counter and timeout compare, parametrised by MAX_WAIT. Sized as $clog2(MAX_WAIT+2) bits.
- Top holds the FSM, idx register, one-hot decode and counters. Expected 150–250 lines.

## Test plan
- Defaults, `mem_ack` tied high, `step`=0, one `exec` pulse ⇒ `phase` cycles 1,2,4,8,16 repeatedly; `inst_cnt`=3 after 15 cycles.
- `mem_ack` delayed 3 cycles in phase 0 ⇒ `phase[0]` held 4 cycles, `mem_req` high 4 cycles, `cycle_cnt`=8 after the first instruction.
- `step`=1 ⇒ each `exec` yields exactly one 5-cycle instruction, then IDLE. Extra `exec` pulses during execution have no effect.
- `halt_req` high in phase 4 together with a pending pause ⇒ `halted`=1 and `phase`=0 thereafter. `exec` is ignored until `rst`.
- MAX_WAIT=2, `mem_ack` low ⇒ `err`=1 after the 3rd wait cycle. With the ack arriving on that 3rd cycle, no error.
- `rst` during phase 3 with CNT_W=4 and `inst_cnt`=15 ⇒ all outputs 0. Separately, without reset, a 16th completion wraps `inst_cnt` to 0.

Source files
------------

// File: rtl/simple_seq_pkg.sv
// Shared definitions for the SIMPLE phase sequencer: state encoding and the
// default set of phases that perform a memory access.
package simple_seq_pkg;

  // Sequencer states; HALT and ERR are sticky until reset.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_ERR  = 2'd3
  } seq_state_e;

  // Default phase count and memory-phase mask (fetch in phase 0, operand in phase 3).
  localparam int             DEFAULT_NPHASE   = 5;
  localparam logic [4:0]     DEFAULT_MEM_MASK = 5'b01001;

endpackage

// File: rtl/simple_seq_if.sv
// Control/status bundle between the sequencer and the rest of the SIMPLE core.
// The master side (button logic, decoder, memory, debug display) drives the
// requests; the slave side is the sequencer itself.
interface simple_seq_if #(
  parameter int NPHASE = 5,
  parameter int CNT_W  = 16
);

  logic              exec;
  logic              step;
  logic              halt_req;
  logic              mem_ack;
  logic [NPHASE-1:0] phase;
  logic              mem_req;
  logic              running;
  logic              halted;
  logic              err;
  logic [CNT_W-1:0]  inst_cnt;
  logic [CNT_W-1:0]  cycle_cnt;

  modport master (
    output exec, step, halt_req, mem_ack,
    input  phase, mem_req, running, halted, err, inst_cnt, cycle_cnt
  );

  modport slave (
    input  exec, step, halt_req, mem_ack,
    output phase, mem_req, running, halted, err, inst_cnt, cycle_cnt
  );

endinterface

// File: rtl/simple_seq_wait.sv
// Memory wait-state counter. Counts consecutive cycles of an outstanding,
// unacknowledged memory request and flags the cycle on which the tolerated
// number of wait cycles would be exceeded. An ack in that cycle wins.
module simple_seq_wait #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req_i,
  input  logic mem_ack_i,
  output logic timeout_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 2);

  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              stalled;

  assign stalled   = mem_req_i && !mem_ack_i;
  assign timeout_o = stalled && (wait_q == WAIT_W'(MAX_WAIT));

  // Next count: grow while stalled, otherwise the phase advances or no request is open.
  always_comb begin
    wait_d = '0;
    if (stalled) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Wait counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_d_check: wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/simple_seq.sv
// SIMPLE multi-cycle phase sequencer. Steps a one-hot phase through NPHASE
// phases per instruction, stretching memory phases until mem_ack, and supports
// continuous run, single-step and halt, plus debug instruction/cycle counters.
// Every output is decoded from registered state only.
module simple_seq
  import simple_seq_pkg::*;
#(
  parameter int                NPHASE   = DEFAULT_NPHASE,
  parameter logic [NPHASE-1:0] MEM_MASK = NPHASE'(DEFAULT_MEM_MASK),
  parameter int                MAX_WAIT = 15,
  parameter int                CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  simple_seq_if.slave bus
);

  localparam int               IDX_W    = $clog2(NPHASE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPHASE - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pause_q, pause_d;
  logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  logic inRun;
  logic memPhase;
  logic advance;
  logic timeout;

  assign inRun    = (state_q == ST_RUN);
  assign memPhase = inRun && MEM_MASK[idx_q];
  assign advance  = inRun && (!memPhase || bus.mem_ack);

  simple_seq_wait #(
    .MAX_WAIT (MAX_WAIT)
  ) waitCounter (
    .clk       (clk),
    .rst       (rst),
    .mem_req_i (memPhase),
    .mem_ack_i (bus.mem_ack),
    .timeout_o (timeout)
  );

  // Next-state logic: run/step/pause/halt decisions and instruction counting.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pause_d    = pause_q;
    inst_cnt_d = inst_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.exec) begin
          state_d = ST_RUN;
          idx_d   = '0;
          pause_d = 1'b0;
        end
      end
      ST_RUN: begin
        pause_d = pause_q | (bus.exec & ~bus.step);
        if (timeout) begin
          state_d = ST_ERR;
          idx_d   = '0;
          pause_d = 1'b0;
        end else if (advance) begin
          if (idx_q == LAST_IDX) begin
            inst_cnt_d = inst_cnt_q + CNT_W'(1);
            idx_d      = '0;
            if (bus.halt_req) begin
              state_d = ST_HALT;
              pause_d = 1'b0;
            end else if (bus.step || pause_d) begin
              state_d = ST_IDLE;
              pause_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Cycle counter advances on every executing clock and sticks at all-ones.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (inRun && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end
  end

  // State, phase index, pause flag and counters, all with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pause_q     <= 1'b0;
      inst_cnt_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pause_q     <= pause_d;
      inst_cnt_q  <= inst_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign bus.phase     = inRun ? (NPHASE'(1) << idx_q) : '0;
  assign bus.mem_req   = memPhase;
  assign bus.running   = inRun;
  assign bus.halted    = (state_q == ST_HALT);
  assign bus.err       = (state_q == ST_ERR);
  assign bus.inst_cnt  = inst_cnt_q;
  assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_simple_seq.sv
// Self-checking bench for simple_seq: a fixed vector table for the basic
// run/wait/pause flow, hand-written corner sequences, then random stimulus
// compared every cycle against a behavioural model of the sequencer.
module tb_simple_seq;

  localparam int         NPHASE   = 5;
  localparam int         MASK_INT = 9;
  localparam logic [4:0] MASK     = 5'b01001;
  localparam int         MAX_WAIT = 3;
  localparam int         CNT_W    = 4;
  localparam int         CNT_MAX  = 15;

  logic clk = 1'b0;
  logic rst;

  simple_seq_if #(.NPHASE(NPHASE), .CNT_W(CNT_W)) busIf ();

  simple_seq #(
    .NPHASE   (NPHASE),
    .MEM_MASK (MASK),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum {Idle, Running, Halted, Failed} modeT;
  modeT mMode  = Idle;
  int   mPhase = 0;
  int   mWait  = 0;
  bit   mPause = 1'b0;
  int   mInst  = 0;
  int   mCycles = 0;

  typedef struct {
    logic       exec, step, halt, ack, rst;
    logic [4:0] phase;
    logic       memReq, running, halted, err;
    logic [3:0] inst, cycle;
  } vecT;

  vecT vectors [16];

  function automatic bit isMemPhase(input int p);
    return ((MASK_INT >> p) & 1) == 1;
  endfunction

  // Behavioural model: one call per rising edge with the inputs seen at that edge.
  task automatic modelUpdate(input logic e, input logic s, input logic h, input logic a, input logic r);
    if (r) begin
      mMode = Idle; mPhase = 0; mWait = 0; mPause = 1'b0; mInst = 0; mCycles = 0;
    end else begin
      case (mMode)
        Idle: begin
          if (e) begin
            mMode = Running; mPhase = 0; mWait = 0; mPause = 1'b0;
          end
        end
        Running: begin
          mCycles++;
          if (e && !s) mPause = 1'b1;
          if (isMemPhase(mPhase) && !a) begin
            mWait++;
            if (mWait > MAX_WAIT) mMode = Failed;
          end else begin
            mWait = 0;
            if (mPhase == NPHASE - 1) begin
              mInst++;
              mPhase = 0;
              if (h) mMode = Halted;
              else if (s || mPause) begin
                mMode = Idle; mPause = 1'b0;
              end
            end else begin
              mPhase++;
            end
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance through the rising edge, update the model, settle.
  task automatic applyStimulus(input logic e, input logic s, input logic h, input logic a, input logic r);
    busIf.exec     = e;
    busIf.step     = s;
    busIf.halt_req = h;
    busIf.mem_ack  = a;
    rst            = r;
    @(posedge clk);
    modelUpdate(e, s, h, a, r);
    #1;
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Compare every DUT output against the behavioural model.
  task automatic checkOutput(input string tag);
    int expPhase, expMemReq, expRun, expHalt, expErr, expInst, expCycle;
    expRun    = (mMode == Running) ? 1 : 0;
    expHalt   = (mMode == Halted) ? 1 : 0;
    expErr    = (mMode == Failed) ? 1 : 0;
    expPhase  = expRun ? (1 << mPhase) : 0;
    expMemReq = (expRun && isMemPhase(mPhase)) ? 1 : 0;
    expInst   = mInst % (CNT_MAX + 1);
    expCycle  = (mCycles > CNT_MAX) ? CNT_MAX : mCycles;
    checks++;
    if (int'(busIf.phase) != expPhase || int'(busIf.mem_req) != expMemReq ||
        int'(busIf.running) != expRun || int'(busIf.halted) != expHalt ||
        int'(busIf.err) != expErr || int'(busIf.inst_cnt) != expInst ||
        int'(busIf.cycle_cnt) != expCycle) begin
      errors++;
      $display("[TB] FAIL %s: got phase=%0d memReq=%0d run=%0d halt=%0d err=%0d inst=%0d cycle=%0d, expected phase=%0d memReq=%0d run=%0d halt=%0d err=%0d inst=%0d cycle=%0d",
               tag, busIf.phase, busIf.mem_req, busIf.running, busIf.halted, busIf.err,
               busIf.inst_cnt, busIf.cycle_cnt, expPhase, expMemReq, expRun, expHalt,
               expErr, expInst, expCycle);
    end
  endtask

  task automatic runCycles(input int n, input logic e, input logic s, input logic h, input logic a, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(e, s, h, a, 1'b0);
      checkOutput(tag);
    end
  endtask

  // Main test sequence: vector table, corner sequences, random run.
  initial begin
    int runningSeen;
    logic re, rs, rh, ra, rr;

    vectors[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 5'd0,  1'b0,1'b0,1'b0,1'b0, 4'd0, 4'd0};
    vectors[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 5'd1,  1'b1,1'b1,1'b0,1'b0, 4'd0, 4'd0};
    vectors[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd2,  1'b0,1'b1,1'b0,1'b0, 4'd0, 4'd1};
    vectors[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd4,  1'b0,1'b1,1'b0,1'b0, 4'd0, 4'd2};
    vectors[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd8,  1'b1,1'b1,1'b0,1'b0, 4'd0, 4'd3};
    vectors[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd16, 1'b0,1'b1,1'b0,1'b0, 4'd0, 4'd4};
    vectors[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd1,  1'b1,1'b1,1'b0,1'b0, 4'd1, 4'd5};
    vectors[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 5'd1,  1'b1,1'b1,1'b0,1'b0, 4'd1, 4'd6};
    vectors[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 5'd1,  1'b1,1'b1,1'b0,1'b0, 4'd1, 4'd7};
    vectors[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 5'd1,  1'b1,1'b1,1'b0,1'b0, 4'd1, 4'd8};
    vectors[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd2,  1'b0,1'b1,1'b0,1'b0, 4'd1, 4'd9};
    vectors[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd4,  1'b0,1'b1,1'b0,1'b0, 4'd1, 4'd10};
    vectors[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd8,  1'b1,1'b1,1'b0,1'b0, 4'd1, 4'd11};
    vectors[13] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 5'd16, 1'b0,1'b1,1'b0,1'b0, 4'd1, 4'd12};
    vectors[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd0,  1'b0,1'b0,1'b0,1'b0, 4'd2, 4'd13};
    vectors[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd0,  1'b0,1'b0,1'b0,1'b0, 4'd2, 4'd13};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vectors[i].exec, vectors[i].step, vectors[i].halt, vectors[i].ack, vectors[i].rst);
      checks++;
      if (busIf.phase !== vectors[i].phase || busIf.mem_req !== vectors[i].memReq ||
          busIf.running !== vectors[i].running || busIf.halted !== vectors[i].halted ||
          busIf.err !== vectors[i].err || busIf.inst_cnt !== vectors[i].inst ||
          busIf.cycle_cnt !== vectors[i].cycle) begin
        errors++;
        $display("[TB] FAIL vector%0d: got phase=%0d memReq=%0d run=%0d halt=%0d err=%0d inst=%0d cycle=%0d, expected phase=%0d memReq=%0d run=%0d halt=%0d err=%0d inst=%0d cycle=%0d",
                 i, busIf.phase, busIf.mem_req, busIf.running, busIf.halted, busIf.err,
                 busIf.inst_cnt, busIf.cycle_cnt, vectors[i].phase, vectors[i].memReq,
                 vectors[i].running, vectors[i].halted, vectors[i].err, vectors[i].inst,
                 vectors[i].cycle);
      end
    end

    // Step mode: one instruction per exec, extra exec mid-instruction ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("stepReset");
    runningSeen = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("stepStart");
    runningSeen += int'(busIf.running);
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 1), 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("stepRun");
      runningSeen += int'(busIf.running);
    end
    checkValue("stepRunningCycles", runningSeen, 5);
    checkValue("stepIdleAfter", int'(busIf.running), 0);
    checkValue("stepInstCount", int'(busIf.inst_cnt), 1);
    runCycles(1, 1'b0, 1'b1, 1'b0, 1'b1, "stepIdle");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkValue("stepRestartPhase", int'(busIf.phase), 1);

    // Halt together with a pending pause: halt wins and is sticky.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("haltStart");
    runCycles(1, 1'b1, 1'b0, 1'b0, 1'b1, "haltPause");
    runCycles(3, 1'b0, 1'b0, 1'b0, 1'b1, "haltRun");
    runCycles(1, 1'b0, 1'b0, 1'b1, 1'b1, "haltBoundary");
    checkValue("haltedSet", int'(busIf.halted), 1);
    checkValue("haltedPhaseZero", int'(busIf.phase), 0);
    runCycles(4, 1'b1, 1'b0, 1'b0, 1'b1, "haltExecIgnored");
    checkValue("haltedStill", int'(busIf.halted), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkValue("haltClearedByReset", int'(busIf.halted), 0);

    // Timeout: MAX_WAIT unacked cycles tolerated, the next one errors.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runCycles(MAX_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, "waitTolerated");
    checkValue("noErrYet", int'(busIf.err), 0);
    runCycles(1, 1'b0, 1'b0, 1'b0, 1'b0, "waitTimeout");
    checkValue("errSet", int'(busIf.err), 1);
    runCycles(3, 1'b1, 1'b0, 1'b0, 1'b1, "errSticky");
    checkValue("errStillSet", int'(busIf.err), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runCycles(MAX_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, "waitAckLate");
    runCycles(1, 1'b0, 1'b0, 1'b0, 1'b1, "ackOnTimeoutCycle");
    checkValue("ackWinsNoErr", int'(busIf.err), 0);
    checkValue("ackWinsPhase1", int'(busIf.phase), 2);

    // Counter saturation, reset mid-instruction, then instruction count wrap.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    runCycles(78, 1'b0, 1'b0, 1'b0, 1'b1, "longRun");
    checkValue("instBeforeReset", int'(busIf.inst_cnt), 15);
    checkValue("phase3BeforeReset", int'(busIf.phase), 8);
    checkValue("cycleSaturated", int'(busIf.cycle_cnt), CNT_MAX);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("midReset");
    checkValue("midResetOutputs",
               int'({busIf.phase, busIf.mem_req, busIf.running, busIf.halted, busIf.err,
                     busIf.inst_cnt, busIf.cycle_cnt}), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    runCycles(75, 1'b0, 1'b0, 1'b0, 1'b1, "wrapRun");
    checkValue("instAt15", int'(busIf.inst_cnt), 15);
    runCycles(5, 1'b0, 1'b0, 1'b0, 1'b1, "wrapRun");
    checkValue("instWrapped", int'(busIf.inst_cnt), 0);
    checkValue("stillRunning", int'(busIf.running), 1);

    // Random stimulus against the model.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      rr = ($urandom_range(0, 59) == 0);
      re = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 3) == 0);
      rh = ($urandom_range(0, 11) == 0);
      ra = ($urandom_range(0, 2) != 0);
      applyStimulus(re, rs, rh, ra, rr);
      checkOutput("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
